// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by both the receiver and the transmitter.
//   - rx_state_e      : receiver state encoding
//   - baud_div()      : baud select -> clock divider (bit period = DIV+1 clks)
//   - FRAME_DATA_BITS : data bits per frame
//   - STOP_LEVEL      : line level expected during the stop bit
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int   FRAME_DATA_BITS = 8;
    localparam logic STOP_LEVEL      = 1'b1;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_BIT  = 3'd1,
        DATA_BIT   = 3'd2,
        PARITY_BIT = 3'd3,
        STOP_BIT   = 3'd4,
        BREAK_WAIT = 3'd5
    } rx_state_e;

    // Unsupported rates fall back to the slowest divider so the link stays
    // usable at 9600.
    function automatic logic [15:0] baud_div(input logic [16:0] baud);
        logic [15:0] div;
        case (baud)
            17'd9600:   div = 16'd104;
            17'd19200:  div = 16'd52;
            17'd38400:  div = 16'd26;
            17'd57600:  div = 16'd17;
            17'd115200: div = 16'd8;
            default:    div = 16'd104;
        endcase
        return div;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// ----------------------------------------------------------------------------
// uart_rx_if
// AXI-Stream byte channel out of the UART receiver.
//   tdata  : received byte
//   tvalid : byte valid
//   tlast  : mirrors tvalid, every byte is a one-beat packet
//   tready : downstream ready
// ----------------------------------------------------------------------------
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tlast;
    logic                  tready;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/uart_sync.sv
// ----------------------------------------------------------------------------
// uart_sync
// N-flop synchronizer for an asynchronous level. Flops reset to 1 so an idle
// UART line does not look like a start bit coming out of reset.
//   clk_i    : clock
//   rst_n_i  : asynchronous active-low reset
//   i_async  : asynchronous input
//   o_sync   : synchronized output
// ----------------------------------------------------------------------------
module uart_sync #(
    parameter int N = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic i_async,
    output logic o_sync
);

    logic [N-1:0] r_ff;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ff <= '1;
        end else begin
            r_ff <= {r_ff[N-2:0], i_async};
        end
    end

    assign o_sync = r_ff[N-1];

endmodule

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
// UART receiver: 1 start, 8 data (MSB first), even parity, 1 stop. Delivers
// bytes on an AXI-Stream master through a single holding register. Errored
// and overrun bytes are dropped and flagged with one-cycle pulses.
//   clk_i         : system clock
//   rst_n_i       : asynchronous active-low reset
//   boudrate_i    : baud select, sampled only while idle
//   rx_i          : asynchronous serial line, idle high
//   mst_axis      : AXI-Stream master (tdata/tvalid/tlast/tready)
//   parity_err_o  : parity mismatch pulse
//   frame_err_o   : stop bit sampled low pulse
//   overrun_o     : byte completed while holding register full pulse
//
// state      | meaning
// -----------+--------------------------------------------------------------
// IDLE       | counter cleared, waiting for falling edge on the line
// START_BIT  | confirm start bit at mid-bit, glitch returns to IDLE
// DATA_BIT   | shift in 8 data bits, one per bit period
// PARITY_BIT | capture the parity bit
// STOP_BIT   | check stop level and parity, deliver or flag
// BREAK_WAIT | line held low after a framing error, wait for it to go high
// ----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [16:0] boudrate_i,
    input  logic        rx_i,
    uart_rx_if.master   mst_axis,
    output logic        parity_err_o,
    output logic        frame_err_o,
    output logic        overrun_o
);

    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_START  = START_BIT;
    localparam logic [2:0] ST_DATA   = DATA_BIT;
    localparam logic [2:0] ST_PARITY = PARITY_BIT;
    localparam logic [2:0] ST_STOP   = STOP_BIT;
    localparam logic [2:0] ST_BREAK  = BREAK_WAIT;

    logic                  w_rx_s;
    logic                  w_mid;
    logic                  r_rx_prev;
    logic [2:0]            r_state;
    logic [15:0]           r_cnt;
    logic [15:0]           r_div;
    logic [2:0]            r_bit_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic                  r_tvalid;
    logic                  r_pe;
    logic                  r_fe;
    logic                  r_ov;

    uart_sync #(.N(SYNC_STAGES)) u_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .i_async (rx_i),
        .o_sync  (w_rx_s)
    );

    // The counter free-runs 0..DIV from the start edge, so every sample after
    // the start-bit check lands exactly one bit period after the previous one.
    assign w_mid = (r_cnt == (r_div >> 1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rx_prev <= 1'b1;
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_div     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_tdata   <= '0;
            r_tvalid  <= 1'b0;
            r_pe      <= 1'b0;
            r_fe      <= 1'b0;
            r_ov      <= 1'b0;
        end else begin
            r_rx_prev <= w_rx_s;
            r_pe      <= 1'b0;
            r_fe      <= 1'b0;
            r_ov      <= 1'b0;

            if (r_tvalid && mst_axis.tready) begin
                r_tvalid <= 1'b0;
            end

            // Divider is latched only while idle, so a baud change mid-frame
            // applies to the next frame.
            if (r_state == ST_IDLE) begin
                r_cnt <= '0;
                r_div <= baud_div(boudrate_i);
            end else begin
                r_cnt <= (r_cnt == r_div) ? 16'd0 : r_cnt + 16'd1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (r_rx_prev && !w_rx_s) begin
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_mid) begin
                        if (w_rx_s) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state   <= ST_DATA;
                            r_bit_idx <= '0;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_mid) begin
                        r_shift <= {r_shift[DATA_WIDTH-2:0], w_rx_s};
                        if (r_bit_idx == 3'(FRAME_DATA_BITS - 1)) begin
                            r_state <= ST_PARITY;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_mid) begin
                        r_par   <= w_rx_s;
                        r_state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_mid) begin
                        if (w_rx_s != STOP_LEVEL) begin
                            r_fe    <= 1'b1;
                            r_state <= ST_BREAK;
                        end else if (r_par != ^r_shift) begin
                            r_pe    <= 1'b1;
                            r_state <= ST_IDLE;
                        end else if (r_tvalid && !mst_axis.tready) begin
                            r_ov    <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            // Also covers a handshake in this same cycle: the
                            // new byte replaces the accepted one.
                            r_tdata  <= r_shift;
                            r_tvalid <= 1'b1;
                            r_state  <= ST_IDLE;
                        end
                    end
                end
                ST_BREAK: begin
                    if (w_rx_s) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mst_axis.tdata  = r_tdata;
    assign mst_axis.tvalid = r_tvalid;
    assign mst_axis.tlast  = r_tvalid;
    assign parity_err_o    = r_pe;
    assign frame_err_o     = r_fe;
    assign overrun_o       = r_ov;

endmodule

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx
// Drives serial frames into uart_rx and compares the delivered bytes and error
// pulse counts against a frame-level reference model.
// ----------------------------------------------------------------------------
module tb_uart_rx;

    logic        clk_i   = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [16:0] boudrate_i;
    logic        rx_i;
    logic        pe, fe, ov;

    uart_rx_if mst_axis ();

    always #5 clk_i = ~clk_i;

    uart_rx dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .boudrate_i   (boudrate_i),
        .rx_i         (rx_i),
        .mst_axis     (mst_axis),
        .parity_err_o (pe),
        .frame_err_o  (fe),
        .overrun_o    (ov)
    );

    int checks = 0;
    int errors = 0;

    // Observed activity
    int         n_pe = 0, n_fe = 0, n_ov = 0, n_vcyc = 0;
    logic [7:0] got_q[$];
    logic [7:0] last_data;
    logic       last_stall = 1'b0;

    // Reference model state
    int         exp_pe = 0, exp_fe = 0, exp_ov = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor samples on the falling edge; inputs change just after rising edges.
    always @(negedge clk_i) begin
        if (rst_n_i) begin
            if (pe) n_pe++;
            if (fe) n_fe++;
            if (ov) n_ov++;
            if (mst_axis.tvalid) n_vcyc++;
            if (mst_axis.tvalid && mst_axis.tready) got_q.push_back(mst_axis.tdata);
            if (mst_axis.tvalid) begin
                checks++;
                assert (mst_axis.tlast === 1'b1) else begin
                    errors++;
                    $error("FAIL tlast: observed %b expected 1", mst_axis.tlast);
                end
            end
            if (last_stall) begin
                checks++;
                assert (mst_axis.tvalid === 1'b1 && mst_axis.tdata === last_data) else begin
                    errors++;
                    $error("FAIL hold: observed v=%b d=0x%0h expected v=1 d=0x%0h",
                           mst_axis.tvalid, mst_axis.tdata, last_data);
                end
            end
            last_stall = mst_axis.tvalid && !mst_axis.tready;
            last_data  = mst_axis.tdata;
        end else begin
            last_stall = 1'b0;
        end
    end

    function automatic int ref_div(input int baud);
        case (baud)
            9600:    return 104;
            19200:   return 52;
            38400:   return 26;
            57600:   return 17;
            115200:  return 8;
            default: return 104;
        endcase
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int div);
        rx_i = 1'b0;
        wait_cyc(div + 1);
        for (int i = 7; i >= 0; i--) begin
            rx_i = d[i];
            wait_cyc(div + 1);
        end
        rx_i = par;
        wait_cyc(div + 1);
        rx_i = stop;
        wait_cyc(div + 1);
    endtask

    // Frame-level model: stop low > parity wrong > overrun > deliver.
    task automatic model_frame(input logic [7:0] d, input logic par, input logic stop,
                               input logic held, input logic ready);
        if (!stop)               exp_fe++;
        else if (par != ^d)      exp_pe++;
        else if (held && !ready) exp_ov++;
        else if (ready)          exp_q.push_back(d);
    endtask

    task automatic check_totals(input string tag);
        chk({tag, "_parity_err"}, n_pe, exp_pe);
        chk({tag, "_frame_err"},  n_fe, exp_fe);
        chk({tag, "_overrun"},    n_ov, exp_ov);
        chk({tag, "_nbytes"},     got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk({tag, "_byte"}, got_q[i], exp_q[i]);
    endtask

    initial begin
        int         bauds[6];
        int         div, kind, vc;
        logic [7:0] d;
        logic       par, stop;

        bauds = '{9600, 19200, 38400, 57600, 115200, 12345};
        rx_i            = 1'b1;
        boudrate_i      = 17'd115200;
        mst_axis.tready = 1'b1;
        wait_cyc(3);

        chk("rst_tvalid", mst_axis.tvalid, 0);
        chk("rst_tdata",  mst_axis.tdata,  0);
        chk("rst_tlast",  mst_axis.tlast,  0);
        chk("rst_pe",     pe, 0);
        chk("rst_fe",     fe, 0);
        chk("rst_ov",     ov, 0);
        rst_n_i = 1'b1;
        wait_cyc(4);

        // 0xA5 at 115200, one-cycle valid
        div = ref_div(115200);
        send_frame(8'hA5, ^8'hA5, 1'b1, div);
        model_frame(8'hA5, ^8'hA5, 1'b1, 1'b0, 1'b1);
        wait_cyc(3);
        chk("a5_valid_cycles", n_vcyc, 1);
        check_totals("a5");

        // 0x3C at 9600 with wrong parity
        boudrate_i = 17'd9600;
        wait_cyc(2);
        div = ref_div(9600);
        send_frame(8'h3C, ~(^8'h3C), 1'b1, div);
        model_frame(8'h3C, ~(^8'h3C), 1'b1, 1'b0, 1'b1);
        wait_cyc(3);
        chk("par_valid_cycles", n_vcyc, 1);
        check_totals("parity");

        // 0x81 at 57600 with low stop, line held low, then 0x42
        boudrate_i = 17'd57600;
        wait_cyc(2);
        div = ref_div(57600);
        send_frame(8'h81, ^8'h81, 1'b0, div);
        model_frame(8'h81, ^8'h81, 1'b0, 1'b0, 1'b1);
        wait_cyc(30 * (div + 1));
        check_totals("break_low");
        rx_i = 1'b1;
        wait_cyc(3 * (div + 1));
        send_frame(8'h42, ^8'h42, 1'b1, div);
        model_frame(8'h42, ^8'h42, 1'b1, 1'b0, 1'b1);
        wait_cyc(3);
        check_totals("break_after");

        // Overrun: two back-to-back frames with tready low
        boudrate_i = 17'd115200;
        mst_axis.tready = 1'b0;
        wait_cyc(2);
        div = ref_div(115200);
        send_frame(8'h11, ^8'h11, 1'b1, div);
        model_frame(8'h11, ^8'h11, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, ^8'h22, 1'b1, div);
        model_frame(8'h22, ^8'h22, 1'b1, 1'b1, 1'b0);
        wait_cyc(3);
        chk("ovr_tvalid", mst_axis.tvalid, 1);
        chk("ovr_tdata",  mst_axis.tdata,  8'h11);
        check_totals("overrun");
        mst_axis.tready = 1'b1;
        exp_q.push_back(8'h11);
        wait_cyc(3);
        chk("ovr_drain_tvalid", mst_axis.tvalid, 0);
        check_totals("overrun_drain");

        // Glitch at 19200: 3 low cycles must not start a frame
        boudrate_i = 17'd19200;
        wait_cyc(2);
        div = ref_div(19200);
        vc = n_vcyc;
        rx_i = 1'b0;
        wait_cyc(3);
        rx_i = 1'b1;
        wait_cyc(2 * (div + 1));
        chk("glitch_valid_cycles", n_vcyc, vc);
        check_totals("glitch");

        // Reset during DATA_BIT clears a held byte and the partial frame
        boudrate_i = 17'd115200;
        mst_axis.tready = 1'b0;
        wait_cyc(2);
        div = ref_div(115200);
        send_frame(8'h5A, ^8'h5A, 1'b1, div);
        model_frame(8'h5A, ^8'h5A, 1'b1, 1'b0, 1'b0);
        wait_cyc(3);
        chk("pre_rst_tvalid", mst_axis.tvalid, 1);
        chk("pre_rst_tdata",  mst_axis.tdata,  8'h5A);
        rx_i = 1'b0;
        wait_cyc(div + 1);
        for (int i = 7; i >= 4; i--) begin
            rx_i = 1'b1;
            wait_cyc(div + 1);
        end
        rst_n_i = 1'b0;
        #1;
        chk("midrst_tvalid", mst_axis.tvalid, 0);
        chk("midrst_tdata",  mst_axis.tdata,  0);
        chk("midrst_flags",  {pe, fe, ov}, 0);
        rx_i = 1'b1;
        wait_cyc(2);
        rst_n_i = 1'b1;
        mst_axis.tready = 1'b1;
        wait_cyc(3);
        send_frame(8'h0F, ^8'h0F, 1'b1, div);
        model_frame(8'h0F, ^8'h0F, 1'b1, 1'b0, 1'b1);
        wait_cyc(3);
        check_totals("post_rst");

        // Randomized frames across all baud selects and error types
        for (int n = 0; n < 10; n++) begin
            boudrate_i = 17'(bauds[$urandom_range(0, 5)]);
            wait_cyc(2);
            div  = ref_div(int'(boudrate_i));
            d    = 8'($urandom);
            kind = int'($urandom_range(0, 3));
            par  = (kind == 2) ? ~(^d) : ^d;
            stop = (kind == 3) ? 1'b0 : 1'b1;
            send_frame(d, par, stop, div);
            model_frame(d, par, stop, 1'b0, 1'b1);
            rx_i = 1'b1;
            wait_cyc(2 * (div + 1));
            check_totals("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
